// File: rtl/fifo_rd_packer.sv
// rtl/fifo_rd_packer.sv - drains fifo_async read side, packs bytes little-endian into LANES-wide words
module fifo_rd_packer #(
  parameter int WIDTH   = 8,
  parameter int LANES   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       fifo_empty_i,
  input  logic [WIDTH-1:0]           fifo_rdata_i,
  input  logic                       fifo_rd_error_i,
  output logic                       fifo_rd_valid_o,
  input  logic                       flush_i,
  output logic [WIDTH*LANES-1:0]     word_o,
  output logic [$clog2(LANES):0]     word_bytes_o,
  output logic                       word_valid_o,
  input  logic                       word_ready_i,
  output logic                       err_o
);

  localparam int CW = $clog2(LANES) + 1;
  localparam int IW = $clog2(TIMEOUT + 1);

  typedef enum logic {FILL, HOLD} state_e;

  state_e                 state_q, state_d;
  logic [WIDTH*LANES-1:0] asm_q, asm_d, asm_cap;
  logic [CW-1:0]          lane_cnt_q, lane_cnt_d, cnt_cap;
  logic                   pend_q, pend_d;
  logic [WIDTH*LANES-1:0] word_q, word_d;
  logic [CW-1:0]          bytes_q, bytes_d;
  logic                   valid_q, valid_d;
  logic [IW-1:0]          idle_q, idle_d;
  logic                   flush_q, flush_d;
  logic                   err_q, err_d;

  logic flush_eff, slot_free, lane_busy, commit_req, commit, rd;
  logic trig_full, trig_to, trig_fl;

  always_comb begin
    flush_eff = flush_i | flush_q;
    slot_free = !valid_q || word_ready_i;
    lane_busy = (lane_cnt_q != '0);

    // assembly image including the byte landing at this edge
    asm_cap = asm_q;
    for (int i = 0; i < LANES; i++) begin
      if (pend_q && lane_cnt_q == CW'(i)) asm_cap[i*WIDTH +: WIDTH] = fifo_rdata_i;
    end
    cnt_cap = lane_cnt_q + {{(CW-1){1'b0}}, pend_q};

    trig_full  = pend_q && (lane_cnt_q == CW'(LANES - 1));
    trig_to    = lane_busy && (idle_q == IW'(TIMEOUT));
    trig_fl    = flush_eff && lane_busy && !pend_q;
    commit_req = (state_q == HOLD) || (state_q == FILL && (trig_full || trig_to || trig_fl));
    commit     = commit_req && slot_free;

    // a committing edge empties the assembly, so the next byte always has room
    rd = !fifo_empty_i && (state_q == FILL) && !flush_eff &&
         ((cnt_cap < CW'(LANES)) || commit);
  end

  always_comb begin
    state_d    = state_q;
    asm_d      = asm_q;
    lane_cnt_d = lane_cnt_q;
    pend_d     = rd;
    word_d     = word_q;
    bytes_d    = bytes_q;
    valid_d    = valid_q;
    idle_d     = idle_q;
    flush_d    = flush_eff;
    err_d      = err_q | fifo_rd_error_i;

    if (commit) begin
      word_d     = asm_cap;
      bytes_d    = cnt_cap;
      valid_d    = 1'b1;
      asm_d      = '0;
      lane_cnt_d = '0;
    end else begin
      if (valid_q && word_ready_i) valid_d = 1'b0;
      if (pend_q) begin
        asm_d      = asm_cap;
        lane_cnt_d = cnt_cap;
      end
    end

    if (commit || pend_q || !lane_busy) begin
      idle_d = '0;
    end else if (state_q == FILL && !rd) begin
      idle_d = idle_q + IW'(1);
    end

    if (commit || (!lane_busy && !pend_q)) flush_d = 1'b0;

    case (state_q)
      FILL:    if (commit_req && !slot_free) state_d = HOLD;
      HOLD:    if (slot_free) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= FILL;
      asm_q      <= '0;
      lane_cnt_q <= '0;
      pend_q     <= 1'b0;
      word_q     <= '0;
      bytes_q    <= '0;
      valid_q    <= 1'b0;
      idle_q     <= '0;
      flush_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      asm_q      <= asm_d;
      lane_cnt_q <= lane_cnt_d;
      pend_q     <= pend_d;
      word_q     <= word_d;
      bytes_q    <= bytes_d;
      valid_q    <= valid_d;
      idle_q     <= idle_d;
      flush_q    <= flush_d;
      err_q      <= err_d;
    end
  end

  assign fifo_rd_valid_o = rd;
  assign word_o          = word_q;
  assign word_bytes_o    = bytes_q;
  assign word_valid_o    = valid_q;
  assign err_o           = err_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb/tb_fifo_rd_packer.sv - directed self-checking bench for fifo_rd_packer
module tb_fifo_rd_packer;
  localparam int WIDTH   = 8;
  localparam int LANES   = 4;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        fifo_empty;
  logic [7:0]  fifo_rdata = '0;
  logic        fifo_rd_error = 1'b0;
  logic        fifo_rd_valid;
  logic        flush = 1'b0;
  logic [31:0] word;
  logic [2:0]  word_bytes;
  logic        word_valid;
  logic        word_ready = 1'b1;
  logic        err;

  int total = 0;
  int bad = 0;

  fifo_rd_packer #(.WIDTH(WIDTH), .LANES(LANES), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .fifo_empty_i(fifo_empty), .fifo_rdata_i(fifo_rdata),
    .fifo_rd_error_i(fifo_rd_error), .fifo_rd_valid_o(fifo_rd_valid),
    .flush_i(flush),
    .word_o(word), .word_bytes_o(word_bytes), .word_valid_o(word_valid),
    .word_ready_i(word_ready), .err_o(err)
  );

  always #5 clk = ~clk;

  // FIFO model: one-cycle read latency, emptied by reset
  logic [7:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr     <= wr_ptr;
      fifo_rdata <= '0;
    end else if (fifo_rd_valid && rd_ptr < 64) begin
      fifo_rdata <= mem[rd_ptr];
      rd_ptr     <= rd_ptr + 1;
    end
  end

  int strobe_cnt = 0, run = 0, maxrun = 0, bad_strobe = 0, cap_cnt = 0;
  logic [31:0] cap_word  [0:63];
  logic [2:0]  cap_bytes [0:63];

  always @(posedge clk) begin
    if (rst_n) begin
      if (fifo_rd_valid) begin
        strobe_cnt <= strobe_cnt + 1;
        run        <= run + 1;
        if (run + 1 > maxrun) maxrun <= run + 1;
        if (fifo_empty) bad_strobe <= bad_strobe + 1;
      end else begin
        run <= 0;
      end
      if (word_valid && word_ready && cap_cnt < 64) begin
        cap_word[cap_cnt]  <= word;
        cap_bytes[cap_cnt] <= word_bytes;
        cap_cnt            <= cap_cnt + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr++;
  endtask

  task automatic wait_words(input int base, input int n, input string tag);
    int k = 0;
    while (cap_cnt < base + n && k < 200) begin
      @(negedge clk);
      k++;
    end
    repeat (6) @(negedge clk);
    check(tag, 32'(cap_cnt - base), 32'(n));
  endtask

  int base, sbase, n;

  initial begin
    // reset values
    #2 rst_n = 1'b0;
    #1;
    check("rst_word", word, 32'h0);
    check("rst_bytes", 32'(word_bytes), 32'd0);
    check("rst_valid", 32'(word_valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rdv", 32'(fifo_rd_valid), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // streaming
    base = cap_cnt;
    for (int i = 1; i <= 8; i++) push(8'(i));
    wait_words(base, 2, "stream_cnt");
    check("stream_run", 32'(maxrun), 32'd8);
    check("stream_w0", cap_word[base], 32'h04030201);
    check("stream_b0", 32'(cap_bytes[base]), 32'd4);
    check("stream_w1", cap_word[base+1], 32'h08070605);
    check("stream_b1", 32'(cap_bytes[base+1]), 32'd4);

    // backpressure
    word_ready = 1'b0;
    base = cap_cnt;
    sbase = strobe_cnt;
    for (int i = 9; i <= 20; i++) push(8'(i));
    repeat (20) @(negedge clk);
    check("bp_strobes", 32'(strobe_cnt - sbase), 32'd8);
    check("bp_rdv", 32'(fifo_rd_valid), 32'd0);
    check("bp_valid", 32'(word_valid), 32'd1);
    check("bp_word", word, 32'h0C0B0A09);
    word_ready = 1'b1;
    wait_words(base, 3, "bp_cnt");
    check("bp_w0", cap_word[base], 32'h0C0B0A09);
    check("bp_w1", cap_word[base+1], 32'h100F0E0D);
    check("bp_w2", cap_word[base+2], 32'h14131211);
    check("bp_total", 32'(strobe_cnt - sbase), 32'd12);

    // timeout
    @(negedge clk);
    base = cap_cnt;
    push(8'hAA); push(8'hBB); push(8'hCC);
    n = 0;
    while (n < 60) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (word_valid) break;
    end
    check("to_latency", 32'(n), 32'(TIMEOUT + 5));
    check("to_word", word, 32'h00CCBBAA);
    check("to_bytes", 32'(word_bytes), 32'd3);
    wait_words(base, 1, "to_cnt");

    // flush with second byte in flight
    @(negedge clk);
    base = cap_cnt;
    push(8'h31); push(8'h32);
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("fl_early", 32'(word_valid), 32'd0);
    @(negedge clk);
    check("fl_valid", 32'(word_valid), 32'd1);
    check("fl_word", word, 32'h00003231);
    check("fl_bytes", 32'(word_bytes), 32'd2);
    wait_words(base, 1, "fl_cnt");

    // flush with empty assembly
    base = cap_cnt;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (5) @(negedge clk);
    check("fle_valid", 32'(word_valid), 32'd0);
    check("fle_cnt", 32'(cap_cnt - base), 32'd0);
    check("empty_rdv", 32'(fifo_rd_valid), 32'd0);

    // sticky error
    fifo_rd_error = 1'b1;
    @(negedge clk);
    fifo_rd_error = 1'b0;
    repeat (5) @(negedge clk);
    check("err_sticky", 32'(err), 32'd1);

    // reset mid-stream
    word_ready = 1'b0;
    for (int i = 'h41; i <= 'h46; i++) push(8'(i));
    repeat (10) @(negedge clk);
    check("mr_pre_valid", 32'(word_valid), 32'd1);
    check("mr_pre_word", word, 32'h44434241);
    rst_n = 1'b0;
    #1;
    check("mr_word", word, 32'h0);
    check("mr_bytes", 32'(word_bytes), 32'd0);
    check("mr_valid", 32'(word_valid), 32'd0);
    check("mr_err", 32'(err), 32'd0);
    check("mr_rdv", 32'(fifo_rd_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    word_ready = 1'b1;
    @(negedge clk);
    base = cap_cnt;
    for (int i = 'h61; i <= 'h64; i++) push(8'(i));
    wait_words(base, 1, "mr_cnt");
    check("mr_new_word", cap_word[base], 32'h64636261);
    check("mr_new_bytes", 32'(cap_bytes[base]), 32'd4);

    check("no_strobe_empty", 32'(bad_strobe), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
